// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - symbolic MIPS32 command encoder and instruction-memory loader
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_load, cfg_base  load base word address, flush pipeline, clear status
//   in_valid/in_ready   command handshake; in_op mnemonic plus in_rs/in_rt/in_rd/
//                       in_shamt/in_imm/in_target fields
//   imem_we/imem_ready  instruction-memory write handshake; imem_addr/imem_wdata
//   word_count          words written since reset/cfg_load
//   mem_full            sticky: last address written, writes halted
//   err                 sticky: illegal mnemonic received
//   idle                encode stage and FIFO both empty
module mips_instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_load,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              mem_full,
    output logic              err,
    output logic              idle
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WC_W  = ADDR_W + 1;

    // Mnemonic codes
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_ADDU = 6'd2;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_SUBU = 6'd4;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_XOR  = 6'd7;
    localparam logic [5:0] OP_NOR  = 6'd8;
    localparam logic [5:0] OP_SLT  = 6'd9;
    localparam logic [5:0] OP_SLTU = 6'd10;
    localparam logic [5:0] OP_SLL  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_SRA  = 6'd13;
    localparam logic [5:0] OP_SLLV = 6'd14;
    localparam logic [5:0] OP_SRLV = 6'd15;
    localparam logic [5:0] OP_SRAV = 6'd16;
    localparam logic [5:0] OP_JR   = 6'd17;
    localparam logic [5:0] OP_JALR = 6'd18;
    localparam logic [5:0] OP_ADDI = 6'd19;
    localparam logic [5:0] OP_ANDI = 6'd20;
    localparam logic [5:0] OP_ORI  = 6'd21;
    localparam logic [5:0] OP_XORI = 6'd22;
    localparam logic [5:0] OP_SLTI = 6'd23;
    localparam logic [5:0] OP_LUI  = 6'd24;
    localparam logic [5:0] OP_LW   = 6'd25;
    localparam logic [5:0] OP_SW   = 6'd26;
    localparam logic [5:0] OP_BEQ  = 6'd27;
    localparam logic [5:0] OP_BNE  = 6'd28;
    localparam logic [5:0] OP_BLEZ = 6'd29;
    localparam logic [5:0] OP_BGTZ = 6'd30;
    localparam logic [5:0] OP_J    = 6'd31;
    localparam logic [5:0] OP_JAL  = 6'd32;

    function automatic logic [31:0] rword(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sh,
        input logic [5:0] funct
    );
        return {6'h00, rs, rt, rd, sh, funct};
    endfunction

    function automatic logic [31:0] iword(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

    // Returns {legal, word}; illegal mnemonics yield {0, 32'h0}.
    function automatic logic [32:0] encode(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  sh,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [32:0] r;
        r = {1'b0, 32'h0};
        case (op)
            OP_NOP:  r = {1'b1, 32'h0};
            OP_ADD:  r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h20)};
            OP_ADDU: r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h21)};
            OP_SUB:  r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h22)};
            OP_SUBU: r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h23)};
            OP_AND:  r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h24)};
            OP_OR:   r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h25)};
            OP_XOR:  r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h26)};
            OP_NOR:  r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h27)};
            OP_SLT:  r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h2A)};
            OP_SLTU: r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h2B)};
            // Constant shifts carry shamt and have no rs operand
            OP_SLL:  r = {1'b1, rword(5'd0, rt, rd, sh, 6'h00)};
            OP_SRL:  r = {1'b1, rword(5'd0, rt, rd, sh, 6'h02)};
            OP_SRA:  r = {1'b1, rword(5'd0, rt, rd, sh, 6'h03)};
            OP_SLLV: r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h04)};
            OP_SRLV: r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h06)};
            OP_SRAV: r = {1'b1, rword(rs, rt, rd, 5'd0, 6'h07)};
            OP_JR:   r = {1'b1, rword(rs, 5'd0, 5'd0, 5'd0, 6'h08)};
            OP_JALR: r = {1'b1, rword(rs, 5'd0, rd, 5'd0, 6'h09)};
            OP_ADDI: r = {1'b1, iword(6'h08, rs, rt, imm)};
            OP_ANDI: r = {1'b1, iword(6'h0C, rs, rt, imm)};
            OP_ORI:  r = {1'b1, iword(6'h0D, rs, rt, imm)};
            OP_XORI: r = {1'b1, iword(6'h0E, rs, rt, imm)};
            OP_SLTI: r = {1'b1, iword(6'h0A, rs, rt, imm)};
            OP_LUI:  r = {1'b1, iword(6'h0F, 5'd0, rt, imm)};
            OP_LW:   r = {1'b1, iword(6'h23, rs, rt, imm)};
            OP_SW:   r = {1'b1, iword(6'h2B, rs, rt, imm)};
            OP_BEQ:  r = {1'b1, iword(6'h04, rs, rt, imm)};
            OP_BNE:  r = {1'b1, iword(6'h05, rs, rt, imm)};
            OP_BLEZ: r = {1'b1, iword(6'h06, rs, 5'd0, imm)};
            OP_BGTZ: r = {1'b1, iword(6'h07, rs, 5'd0, imm)};
            OP_J:    r = {1'b1, 6'h02, target};
            OP_JAL:  r = {1'b1, 6'h03, target};
            default: r = {1'b0, 32'h0};
        endcase
        return r;
    endfunction

    // Encode stage
    logic              stage_valid;
    logic [31:0]       stage_word;
    logic [32:0]       enc;

    // Word FIFO
    logic [31:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_full;
    logic              fifo_empty;

    // Write-port state
    logic [ADDR_W-1:0] addr;

    logic              accept;
    logic              push;
    logic              pop;

    assign enc        = encode(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);

    assign in_ready   = !cfg_load && (!stage_valid || !fifo_full);
    assign accept     = in_valid && in_ready;

    assign imem_we    = !fifo_empty && !mem_full && !cfg_load;
    assign pop        = imem_we && imem_ready;
    // A full FIFO still takes the stage word when the head leaves in the same cycle
    assign push       = stage_valid && !cfg_load && (!fifo_full || pop);

    assign imem_addr  = addr;
    assign imem_wdata = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];
    assign idle       = !stage_valid && fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_word  <= 32'h0;
            err         <= 1'b0;
        end else if (cfg_load) begin
            stage_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Illegal commands complete the handshake but never occupy the stage
            if (accept && enc[32]) begin
                stage_valid <= 1'b1;
                stage_word  <= enc[31:0];
            end else if (push) begin
                stage_valid <= 1'b0;
            end
            if (accept && !enc[32]) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= stage_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (cfg_load) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            word_count <= '0;
            mem_full   <= 1'b0;
        end else if (cfg_load) begin
            addr       <= cfg_base;
            word_count <= '0;
            mem_full   <= 1'b0;
        end else if (pop) begin
            word_count <= word_count + WC_W'(1);
            // The top address is the last one: park there and stop writing
            if (&addr) begin
                mem_full <= 1'b1;
            end else begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - self-checking bench for mips_instr_encoder
module tb_mips_instr_encoder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int MAXA   = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_load;
    logic [ADDR_W-1:0] cfg_base;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_op;
    logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              mem_full;
    logic              err;
    logic              idle;

    mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_base(cfg_base),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .word_count(word_count), .mem_full(mem_full),
        .err(err), .idle(idle)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: tables indexed by mnemonic, fields placed by arithmetic
    localparam int FUNCT [0:18] = '{0, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                                     'h2A, 'h2B, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08, 'h09};
    localparam int OPC [0:13] = '{'h08, 'h0C, 'h0D, 'h0E, 'h0A, 'h0F, 'h23, 'h2B,
                                   'h04, 'h05, 'h06, 'h07, 'h02, 'h03};

    function automatic bit [31:0] ref_enc(input int op, input int rs, input int rt, input int rd,
                                          input int sh, input int imm, input int tg);
        bit [31:0] s, t, d, h;
        s = rs; t = rt; d = rd; h = 0;
        if (op == 0) return 32'h0;
        if (op <= 18) begin
            if (op >= 11 && op <= 13) begin h = sh; s = 0; end
            if (op == 17) begin t = 0; d = 0; end
            if (op == 18) t = 0;
            return (s << 21) + (t << 16) + (d << 11) + (h << 6) + 32'(FUNCT[op]);
        end
        if (op <= 30) begin
            if (op == 24) s = 0;
            if (op == 29 || op == 30) t = 0;
            return (32'(OPC[op-19]) << 26) + (s << 21) + (t << 16) + 32'(imm);
        end
        return (32'(OPC[op-19]) << 26) + 32'(tg);
    endfunction

    // Behavioural model: stage and FIFO as word queues
    bit [31:0] m_sq[$];
    bit [31:0] m_fq[$];
    int        m_addr, m_wc;
    bit        m_mf, m_er;
    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];

    function automatic void model_reset();
        m_sq.delete(); m_fq.delete();
        m_addr = 0; m_wc = 0; m_mf = 0; m_er = 0;
    endfunction

    initial model_reset();

    always @(negedge clk) begin
        bit e_rdy, e_we, pop, acc, push;
        if (!rst_n) model_reset();
        e_rdy = !cfg_load && (m_sq.size() == 0 || m_fq.size() < DEPTH);
        e_we  = m_fq.size() > 0 && !m_mf && !cfg_load;
        chk("in_ready", in_ready, e_rdy);
        chk("imem_we", imem_we, e_we);
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, (m_fq.size() > 0) ? m_fq[0] : 32'h0);
        chk("word_count", word_count, m_wc);
        chk("mem_full", mem_full, m_mf);
        chk("err", err, m_er);
        chk("idle", idle, m_sq.size() == 0 && m_fq.size() == 0);
        if (rst_n) begin
            if (imem_we && imem_ready) begin
                obs_addr.push_back(imem_addr);
                obs_data.push_back(imem_wdata);
            end
            if (cfg_load) begin
                model_reset();
                m_addr = cfg_base;
            end else begin
                pop  = e_we && imem_ready;
                acc  = in_valid && e_rdy;
                push = m_sq.size() > 0 && (m_fq.size() < DEPTH || pop);
                if (pop) begin
                    void'(m_fq.pop_front());
                    m_wc++;
                    if (m_addr == MAXA) m_mf = 1; else m_addr++;
                end
                if (push) m_fq.push_back(m_sq.pop_front());
                if (acc) begin
                    if (in_op <= 32)
                        m_sq.push_back(ref_enc(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target));
                    else
                        m_er = 1;
                end
            end
        end
    end

    task automatic do_cfg(input logic [ADDR_W-1:0] base);
        cfg_load = 1'b1; cfg_base = base;
        @(negedge clk);
        chk("cfg_no_write", imem_we, 1'b0);
        chk("cfg_no_accept", in_ready, 1'b0);
        @(posedge clk); #1;
        cfg_load = 1'b0;
        obs_addr.delete(); obs_data.delete();
    endtask

    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int sh, input int imm, input int tg);
        int n;
        n = 0;
        in_valid = 1'b1; in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tg);
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stuck at 0, required 1");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (idle) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL idle_timeout: idle stuck at 0, required 1");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, n;
        rst_n = 1'b0; cfg_load = 1'b0; cfg_base = '0; in_valid = 1'b0; in_op = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
        imem_ready = 1'b1;

        // Model pins
        chk("ref_add", ref_enc(1, 1, 2, 3, 0, 0, 0), 32'h00221820);
        chk("ref_addi", ref_enc(19, 0, 8, 0, 0, 'h5, 0), 32'h20080005);
        chk("ref_sll", ref_enc(11, 7, 1, 2, 4, 0, 0), 32'h00011100);
        chk("ref_lw", ref_enc(25, 29, 4, 0, 0, 'hFFFC, 0), 32'h8FA4FFFC);
        chk("ref_j", ref_enc(31, 0, 0, 0, 0, 0, 'h10), 32'h08000010);
        chk("ref_jr", ref_enc(17, 31, 5, 6, 3, 0, 0), 32'h03E00008);

        #2;
        chk("rst_we", imem_we, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_wdata", imem_wdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single ADD: two cycles from accept to write
        do_cfg(10'h010);
        send(1, 1, 2, 3, 0, 0, 0);
        @(negedge clk);
        chk("lat_n1_we", imem_we, 1'b0);
        @(negedge clk);
        chk("lat_n2_we", imem_we, 1'b1);
        chk("lat_addr", imem_addr, 10'h010);
        chk("lat_wdata", imem_wdata, 32'h00221820);
        @(posedge clk); #1;
        wait_idle();
        chk("add_wc", word_count, 1);

        // Back-to-back mix
        do_cfg(10'h000);
        send(19, 0, 8, 0, 0, 'h0005, 0);
        send(11, 7, 1, 2, 4, 0, 0);
        send(25, 29, 4, 0, 0, 'hFFFC, 0);
        send(31, 0, 0, 0, 0, 0, 'h10);
        wait_idle();
        chk("b2b_wc", word_count, 4);
        chk("b2b_count", obs_data.size(), 4);
        if (obs_data.size() == 4) begin
            chk("b2b_w1", obs_data[1], 32'h00011100);
            chk("b2b_a3", obs_addr[3], 10'h003);
            chk("b2b_w3", obs_data[3], 32'h08000010);
        end

        // Backpressure: 4 FIFO + 1 stage accepted while memory stalls
        do_cfg(10'h100);
        imem_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1; in_op = 6'd19; in_rt = 5'd1; in_rs = 5'd0; in_imm = 16'd0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
            in_imm = 16'(acc);
        end
        chk("bp_accepted", acc, 5);
        imem_ready = 1'b1;
        n = 0;
        while (acc < 6 && n < 50) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
            in_imm = 16'(acc);
            n++;
        end
        in_valid = 1'b0;
        wait_idle();
        chk("bp_words", obs_data.size(), 6);
        if (obs_data.size() == 6) begin
            chk("bp_last_addr", obs_addr[5], 10'h105);
            chk("bp_last_data", obs_data[5], 32'h20010005);
        end

        // Illegal mnemonic between NOPs
        do_cfg(10'h020);
        send(0, 1, 2, 3, 4, 5, 6);
        send(40, 1, 2, 3, 4, 5, 6);
        send(0, 7, 7, 7, 7, 7, 7);
        wait_idle();
        chk("ill_err", err, 1'b1);
        chk("ill_words", obs_data.size(), 2);
        do_cfg(10'h020);
        @(negedge clk);
        chk("ill_err_clr", err, 1'b0);
        @(posedge clk); #1;

        // Top address: one write then halt
        do_cfg(10'h3FF);
        send(1, 1, 2, 3, 0, 0, 0);
        send(3, 4, 5, 6, 0, 0, 0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("top_full", mem_full, 1'b1);
        chk("top_we", imem_we, 1'b0);
        chk("top_idle", idle, 1'b0);
        chk("top_words", obs_data.size(), 1);
        if (obs_data.size() == 1) chk("top_addr", obs_addr[0], 10'h3FF);
        @(posedge clk); #1;

        // Flush with three words buffered
        do_cfg(10'h000);
        imem_ready = 1'b0;
        send(2, 1, 1, 1, 0, 0, 0);
        send(4, 2, 2, 2, 0, 0, 0);
        send(6, 3, 3, 3, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        do_cfg(10'h040);
        @(negedge clk);
        chk("flush_idle", idle, 1'b1);
        chk("flush_wc", word_count, 0);
        @(posedge clk); #1;
        imem_ready = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid   = ($urandom % 4) != 0;
            in_op      = ($urandom % 16 == 0) ? 6'(33 + $urandom % 31) : 6'($urandom % 33);
            in_rs      = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_shamt   = 5'($urandom); in_imm = 16'($urandom); in_target = 26'($urandom);
            imem_ready = ($urandom % 4) != 0;
            cfg_load   = ($urandom % 150) == 0;
            cfg_base   = ($urandom % 2) ? ADDR_W'(MAXA - $urandom % 12) : ADDR_W'($urandom);
            @(posedge clk); #1;
        end
        cfg_load = 1'b0;

        // Reset while the FIFO is full
        do_cfg(10'h080);
        imem_ready = 1'b0; in_valid = 1'b1; in_op = 6'd5;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", imem_we, 1'b0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_wdata", imem_wdata, 32'h0);
        chk("mid_rst_idle", idle, 1'b1);
        chk("mid_rst_wc", word_count, 0);
        in_valid = 1'b0; imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
